// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Package    : dmem_pkg
//  Description: Shared constants and FSM encoding for the data-memory
//               responder (funct3 codes, state encoding, wait-counter width).
//  Revision   : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  // RV32I load/store funct3 codes (stores use only B/H/W)
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Wait-state counter width (supports 0..15 wait states)
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_lane_v.sv
`default_nettype none
// ============================================================================
//  Module     : dmem_lane_v
//  Description: Combinational byte-lane steering for the data-memory
//               responder: store byte mask / replicated write word, load lane
//               select with sign/zero extension, and access-fault detection.
//               Optional macro DMEM_ERR_CHECK_EN enables the misaligned /
//               illegal-funct3 fault output; otherwise the fault is tied 0,
//               low address bits are truncated to natural alignment and an
//               illegal funct3 behaves as a word access.
//  Revision   : 1.0 - initial release
// ============================================================================
module dmem_lane_v
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        we,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  wmask,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        fault
);

  logic        legal;
  logic [1:0]  size_log;
  logic [1:0]  offset;
  logic [15:0] shifted;

  // Decode access size, then steer store lanes and extend the selected load lane
  always_comb begin
    if (we) legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    else    legal = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};

    // Anything illegal is handled as a full-word access
    size_log = legal ? funct3[1:0] : 2'd2;

    // Natural alignment: halves ignore addr[0], words ignore addr[1:0]
    case (size_log)
      2'd0:    offset = addr_lo;
      2'd1:    offset = {addr_lo[1], 1'b0};
      default: offset = 2'b00;
    endcase

    shifted = 16'(rword >> {offset, 3'b000});

    case (size_log)
      2'd0: begin
        wmask = 4'b0001 << offset;
        wword = {4{wdata[7:0]}};
        rdata = funct3[2] ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      2'd1: begin
        wmask = 4'b0011 << offset;
        wword = {2{wdata[15:0]}};
        rdata = funct3[2] ? {16'd0, shifted} : {{16{shifted[15]}}, shifted};
      end
      default: begin
        wmask = 4'b1111;
        wword = wdata;
        rdata = rword;
      end
    endcase

`ifdef DMEM_ERR_CHECK_EN
    fault = !legal
          || ((size_log == 2'd1) && addr_lo[0])
          || ((size_log == 2'd2) && (addr_lo != 2'b00));
`else
    fault = 1'b0;
`endif
  end

endmodule : dmem_lane_v
`default_nettype wire

// File: rtl/dmem_responder_v.sv
`default_nettype none
// ============================================================================
//  Module     : dmem_responder_v
//  Description: Data-memory responder. Accepts one load/store at a time on a
//               valid/ready request channel, inserts WAIT_CYCLES wait states,
//               performs the RAM access on the edge entering RESP and holds
//               the response until rsp_ready. Word-organised RAM with byte
//               lanes; RV32I byte/half/word widths.
//               Optional macro DMEM_ERR_CHECK_EN enables access-fault
//               reporting (misaligned, illegal funct3, out of range).
//  Revision   : 1.0 - initial release
// ============================================================================
module dmem_responder_v
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int              IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;

  logic [31:0]        mem [DEPTH_WORDS];

  logic               accept;
  logic               enter_resp;
  logic               from_req;
  logic               acc_we;
  logic [2:0]         acc_funct3;
  logic [31:0]        acc_addr;
  logic [31:0]        acc_wdata;
  logic [IDX_W-1:0]   idx;
  logic [31:0]        rword;
  logic [3:0]         lane_wmask;
  logic [31:0]        lane_wword;
  logic [31:0]        lane_rdata;
  logic               lane_fault;
  logic               err_now;
  logic               do_write;

  // Ready only in IDLE and never while reset is asserted
  assign req_ready = (state_q == ST_IDLE) && reset;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // With zero wait states the access happens on the accept edge, so the
  // access fields come straight from the request port while in IDLE.
  assign from_req   = (state_q == ST_IDLE);
  assign acc_we     = from_req ? req_we     : we_q;
  assign acc_funct3 = from_req ? req_funct3 : funct3_q;
  assign acc_addr   = from_req ? req_addr   : addr_q;
  assign acc_wdata  = from_req ? req_wdata  : wdata_q;

  assign idx   = acc_addr[IDX_W+1:2];
  assign rword = mem[idx];

  dmem_lane_v u_lane (
    .funct3  (acc_funct3),
    .we      (acc_we),
    .addr_lo (acc_addr[1:0]),
    .wdata   (acc_wdata),
    .rword   (rword),
    .wmask   (lane_wmask),
    .wword   (lane_wword),
    .rdata   (lane_rdata),
    .fault   (lane_fault)
  );

`ifdef DMEM_ERR_CHECK_EN
  assign err_now = lane_fault || (|acc_addr[31:IDX_W+2]);
`else
  // Upper address bits are ignored: the word index wraps modulo DEPTH_WORDS
  logic unused_bits;
  assign unused_bits = ^{lane_fault, acc_addr[31:IDX_W+2]};
  assign err_now     = 1'b0;
`endif

  assign do_write = enter_resp && acc_we && !err_now && reset;

  // Next-state, wait counter, request latch and response capture
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          cnt_d    = WAIT_INIT;
          if (WAIT_CYCLES == 0) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (enter_resp) begin
      err_d   = err_now;
      rdata_d = (acc_we || err_now) ? 32'd0 : lane_rdata;
    end
  end

  // Control and response registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Byte-lane RAM write; contents survive reset
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_wmask[b]) mem[idx][8*b +: 8] <= lane_wword[8*b +: 8];
      end
    end
  end

endmodule : dmem_responder_v
`default_nettype wire

// File: tb/tb_dmem_responder_v.sv
`default_nettype none
// ============================================================================
//  Module     : tb_dmem_responder_v
//  Description: Self-checking bench for dmem_responder_v. Instance A uses
//               two wait states, instance B zero wait states with rsp_ready
//               tied high. Expected data comes from a byte-array memory model.
//               Expectations follow DMEM_ERR_CHECK_EN when it is defined.
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_dmem_responder_v;

  localparam int DEPTH  = 256;
  localparam int WAIT_A = 2;
  localparam int NBYTES = 4 * DEPTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [2:0]  a_req_funct3;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [2:0]  b_req_funct3;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  ref_a [NBYTES];
  logic [7:0]  ref_b [NBYTES];
  logic [31:0] a_last_rd;
  logic        a_last_err;

  dmem_responder_v #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT_A)) u_dut_a (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_funct3(a_req_funct3), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  dmem_responder_v #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_funct3(b_req_funct3), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Byte-addressed reference memory: one call = one complete transaction
  function automatic void model(input bit sel, input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic err, output logic [31:0] rdata);
    int          size;
    int          base;
    bit          legal;
    bit          uns;
    logic [31:0] v;
    legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
    size  = legal ? (1 << f3[1:0]) : 4;
    uns   = legal && !we && f3[2];
    rdata = 32'd0;
    err   = 1'b0;
`ifdef DMEM_ERR_CHECK_EN
    err = !legal || ((addr % size) != 0) || (addr >= NBYTES);
`endif
    if (err) return;
    base = int'(addr % NBYTES);
    base = base - (base % size);
    if (we) begin
      for (int i = 0; i < size; i++) begin
        if (sel) ref_b[base+i] = wdata[8*i +: 8];
        else     ref_a[base+i] = wdata[8*i +: 8];
      end
    end else begin
      v = 32'd0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = sel ? ref_b[base+i] : ref_a[base+i];
      if (size == 1 && !uns) v = {{24{v[7]}}, v[7:0]};
      if (size == 2 && !uns) v = {{16{v[15]}}, v[15:0]};
      rdata = v;
    end
  endfunction

  // One full transaction on instance A with latency, hold and return checks
  task automatic a_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input int hold, input bit scramble);
    logic        exp_err;
    logic [31:0] exp_rd;
    int          k;
    k = 0;
    while (!a_req_ready && k < 20) begin @(negedge clk); k++; end
    chk("a_ready_idle", a_req_ready, 1);
    a_req_valid = 1'b1; a_req_we = we; a_req_funct3 = f3;
    a_req_addr = addr; a_req_wdata = wdata;
    model(1'b0, we, f3, addr, wdata, exp_err, exp_rd);
    @(posedge clk);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (!a_rsp_valid && scramble) begin
        a_req_valid = 1'b1; a_req_we = 1'($urandom); a_req_funct3 = 3'($urandom);
        a_req_addr = $urandom; a_req_wdata = $urandom;
      end else begin
        a_req_valid = 1'b0;
      end
      if (!a_rsp_valid) chk("a_wait_ready", a_req_ready, 0);
    end while (!a_rsp_valid && k < 20);
    a_req_valid = 1'b0;
    chk("a_latency", k, WAIT_A + 1);
    chk("a_rdata", a_rsp_rdata, exp_rd);
    chk("a_err", a_rsp_err, exp_err);
    a_last_rd  = a_rsp_rdata;
    a_last_err = a_rsp_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("a_hold_valid", a_rsp_valid, 1);
      chk("a_hold_rdata", a_rsp_rdata, exp_rd);
      chk("a_hold_ready", a_req_ready, 0);
    end
    a_rsp_ready = 1'b1;
    @(negedge clk);
    a_rsp_ready = 1'b0;
    chk("a_done_valid", a_rsp_valid, 0);
    chk("a_done_ready", a_req_ready, 1);
  endtask

  initial begin
    logic        e_err;
    logic [31:0] e_rd;
    logic [2:0]  f3;
    logic [31:0] ad;
    reset = 1'b0;
    a_req_valid = 0; a_req_we = 0; a_req_funct3 = 0; a_req_addr = 0; a_req_wdata = 0; a_rsp_ready = 0;
    b_req_valid = 0; b_req_we = 0; b_req_funct3 = 0; b_req_addr = 0; b_req_wdata = 0; b_rsp_ready = 1;
    repeat (3) @(negedge clk);
    chk("rst_a_ready", a_req_ready, 0);
    chk("rst_a_valid", a_rsp_valid, 0);
    chk("rst_a_rdata", a_rsp_rdata, 0);
    chk("rst_a_err", a_rsp_err, 0);
    chk("rst_b_ready", b_req_ready, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_a_ready", a_req_ready, 1);
    chk("rel_a_valid", a_rsp_valid, 0);

    // Fill instance A so every later load has defined contents
    for (int w = 0; w < DEPTH; w++) a_txn(1'b1, 3'd2, 32'(4 * w), $urandom, 0, 1'b0);

    // Word store / load
    a_txn(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, 1'b0);
    a_txn(1'b0, 3'd2, 32'h10, 32'h0, 0, 1'b0);
    chk("lw10_const", a_last_rd, 32'hDEADBEEF);

    // Byte and half lanes with sign / zero extension
    a_txn(1'b1, 3'd0, 32'h21, 32'h80, 0, 1'b0);
    a_txn(1'b0, 3'd0, 32'h20, 32'h0, 0, 1'b0);
    a_txn(1'b0, 3'd0, 32'h21, 32'h0, 0, 1'b0);
    chk("lb21_const", a_last_rd, 32'hFFFFFF80);
    a_txn(1'b0, 3'd4, 32'h21, 32'h0, 0, 1'b0);
    chk("lbu21_const", a_last_rd, 32'h00000080);
    a_txn(1'b1, 3'd1, 32'h22, 32'h8001, 0, 1'b0);
    a_txn(1'b0, 3'd5, 32'h22, 32'h0, 0, 1'b0);
    chk("lhu22_const", a_last_rd, 32'h00008001);

    // Response held for five cycles while inputs wiggle
    a_txn(1'b0, 3'd2, 32'h10, 32'h0, 5, 1'b1);

    // Fault cases (expectations depend on the build option)
    a_txn(1'b0, 3'd2, 32'h13, 32'h0, 0, 1'b0);
    a_txn(1'b1, 3'd2, 32'h400, 32'hA5A5A5A5, 0, 1'b0);
    a_txn(1'b0, 3'd2, 32'h0, 32'h0, 0, 1'b0);
    a_txn(1'b0, 3'd3, 32'h8, 32'h0, 0, 1'b0);
`ifdef DMEM_ERR_CHECK_EN
    chk("f3_3_err_const", a_last_err, 1);
`endif

    // Reset pulsed in the middle of a store's wait period
    a_txn(1'b0, 3'd2, 32'h30, 32'h0, 0, 1'b0);
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_funct3 = 3'd2;
    a_req_addr = 32'h30; a_req_wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("rstw_valid", a_rsp_valid, 0);
    chk("rstw_ready", a_req_ready, 0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstw_no_rsp", a_rsp_valid, 0);
    end
    a_txn(1'b0, 3'd2, 32'h30, 32'h0, 0, 1'b0);

    // Randomised traffic, occasionally outside the RAM range
    for (int n = 0; n < 80; n++) begin
      ad = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, NBYTES - 1));
      a_txn(1'($urandom), 3'($urandom), ad, $urandom, $urandom_range(0, 2), 1'($urandom));
    end

    // Zero wait states, back-to-back with rsp_ready high
    b_req_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("b_ready", b_req_ready, 1);
      chk("b_idle_valid", b_rsp_valid, 0);
      if (i < 8) begin
        b_req_we = 1'b1; b_req_funct3 = 3'd2; b_req_addr = 32'(4 * i); b_req_wdata = $urandom;
      end else begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0;
          1: f3 = 3'd1;
          2: f3 = 3'd2;
          3: f3 = 3'd4;
          default: f3 = 3'd5;
        endcase
        ad = 32'($urandom_range(0, 31));
        if (f3[1:0] == 2'd1) ad[0] = 1'b0;
        if (f3[1:0] == 2'd2) ad[1:0] = 2'b00;
        b_req_we = 1'b0; b_req_funct3 = f3; b_req_addr = ad; b_req_wdata = $urandom;
      end
      model(1'b1, b_req_we, b_req_funct3, b_req_addr, b_req_wdata, e_err, e_rd);
      @(negedge clk);
      chk("b_rsp_valid", b_rsp_valid, 1);
      chk("b_rsp_busy", b_req_ready, 0);
      chk("b_rdata", b_rsp_rdata, e_rd);
      chk("b_err", b_rsp_err, e_err);
      @(negedge clk);
    end
    b_req_valid = 1'b0;
    @(negedge clk);
    chk("b_final_valid", b_rsp_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_dmem_responder_v
`default_nettype wire
